// File: rtl/nios_system_reverse_seq.sv
// nios_system_reverse_seq: Avalon-MM motor direction-reversal sequencer.
// A direction change disables the drive for one dead-time, flips
// reverse_out for a single cycle, then holds the drive off for a second
// dead-time before handing drive_en back to the drive_req bit.
// Optional build macro NIOS_SYSTEM_REVERSE_SEQ_IRQ_EN adds the CTRL.irq_en
// bit and the registered sequence-complete interrupt; without it irq is 0.
module nios_system_reverse_seq #(
  parameter logic [15:0] DEADTIME_RST = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        reverse_out,
  output logic        drive_en,
  output logic        irq
);

  localparam int unsigned DT_W = 16;
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DEADTIME = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFF_WAIT = 2'd1,
    FLIP     = 2'd2,
    ON_WAIT  = 2'd3
  } state_t;

  state_t          state;
  logic            target_dir;
  logic            drive_req;
  logic            irq_en;
  logic            done;
  logic [DT_W-1:0] deadtime;
  logic [DT_W-1:0] count;

  logic            wr_ctrl_c;
  logic            wr_deadtime_c;
  logic            wr_status_c;
  logic [DT_W-1:0] load_c;
  logic            mismatch_c;
  logic            seq_end_c;
  logic            busy_c;
  logic            pending_c;
  logic            done_nxt_c;
  logic            unused_c;

  // Bus decode and sequencer status terms
  always_comb begin
    wr_ctrl_c     = chipselect & ~write_n & (address == ADDR_CTRL);
    wr_deadtime_c = chipselect & ~write_n & (address == ADDR_DEADTIME);
    wr_status_c   = chipselect & ~write_n & (address == ADDR_STATUS);
    // A zero dead-time still spends one cycle in each wait state
    load_c        = (deadtime == '0) ? DT_W'(1) : deadtime;
    mismatch_c    = (target_dir != reverse_out);
    busy_c        = (state != IDLE);
    // Only a mismatch left over after the flip is a queued change
    pending_c     = (state == ON_WAIT) & mismatch_c;
    seq_end_c     = (state == ON_WAIT) & (count <= DT_W'(1));
    // Completion wins over a same-cycle write-1-to-clear
    done_nxt_c    = seq_end_c | (done & ~(wr_status_c & writedata[3]));
  end

  assign unused_c = ^writedata[31:DT_W];

  // Combinational zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata = {29'd0, irq_en, drive_req, target_dir};
      ADDR_DEADTIME: readdata = {16'd0, deadtime};
      ADDR_STATUS:   readdata = {28'd0, done, pending_c, busy_c, reverse_out};
      default:       readdata = '0;
    endcase
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_dir <= 1'b0;
      drive_req  <= 1'b0;
      deadtime   <= DEADTIME_RST;
      done       <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        target_dir <= writedata[0];
        drive_req  <= writedata[1];
      end
      if (wr_deadtime_c) begin
        deadtime <= writedata[DT_W-1:0];
      end
      done <= done_nxt_c;
    end
  end

`ifdef NIOS_SYSTEM_REVERSE_SEQ_IRQ_EN
  logic irq_en_nxt_c;

  // Next irq_en so irq tracks done in the same cycle
  always_comb begin
    irq_en_nxt_c = wr_ctrl_c ? writedata[2] : irq_en;
  end

  // Registered level interrupt on sequence completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_nxt_c;
      irq    <= done_nxt_c & irq_en_nxt_c;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Reversal sequencer: state, dead-time counter and motor outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      reverse_out <= 1'b0;
      drive_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mismatch_c) begin
            state    <= OFF_WAIT;
            count    <= load_c;
            drive_en <= 1'b0;
          end else begin
            drive_en <= drive_req;
          end
        end
        OFF_WAIT: begin
          drive_en <= 1'b0;
          count    <= count - DT_W'(1);
          if (count <= DT_W'(1)) begin
            state <= FLIP;
          end
        end
        FLIP: begin
          // Commit the direction this sequence was started for, so a
          // toggle-back during the off phase cannot cancel it half-way
          drive_en    <= 1'b0;
          reverse_out <= ~reverse_out;
          count       <= load_c;
          state       <= ON_WAIT;
        end
        ON_WAIT: begin
          count <= count - DT_W'(1);
          if (seq_end_c) begin
            if (mismatch_c) begin
              // Back-to-back change: drive stays off, no idle cycle
              state    <= OFF_WAIT;
              count    <= load_c;
              drive_en <= 1'b0;
            end else begin
              state    <= IDLE;
              drive_en <= drive_req;
            end
          end else begin
            drive_en <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_reverse_seq.sv
// Bench for nios_system_reverse_seq: directed scenarios plus randomized bus
// traffic, all checked against a phase-counting reference model.
`timescale 1ns/1ps
module tb_nios_system_reverse_seq;

  localparam logic [15:0] DT_RST = 16'd1000;
`ifdef NIOS_SYSTEM_REVERSE_SEQ_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        reverse_out;
  logic        drive_en;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios_system_reverse_seq #(.DEADTIME_RST(DT_RST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .reverse_out(reverse_out),
    .drive_en   (drive_en),
    .irq        (irq)
  );

  // Reference model: remaining cycles of the off phase, a pending flip,
  // and remaining cycles of the on phase.
  logic        m_rev, m_den, m_tgt, m_dreq, m_ien, m_done, m_irq, m_flip;
  logic [15:0] m_dt;
  int unsigned m_off, m_on;

  task automatic model_step();
    logic        idle_b, fin, wr;
    int unsigned n;
    if (!reset_n) begin
      m_rev = 0; m_den = 0; m_tgt = 0; m_dreq = 0; m_ien = 0;
      m_done = 0; m_irq = 0; m_flip = 0; m_dt = DT_RST; m_off = 0; m_on = 0;
      return;
    end
    wr = chipselect & ~write_n;
    n = (m_dt == 16'd0) ? 1 : int'(m_dt);
    idle_b = (m_off == 0) && !m_flip && (m_on == 0);
    fin = 1'b0;
    if (m_off != 0) begin
      m_off = m_off - 1;
      if (m_off == 0) m_flip = 1'b1;
    end else if (m_flip) begin
      m_rev = ~m_rev;
      m_flip = 1'b0;
      m_on = n;
    end else if (m_on != 0) begin
      m_on = m_on - 1;
      fin = (m_on == 0);
    end
    if (idle_b || fin) begin
      if (m_tgt != m_rev) begin
        m_off = n;
        m_den = 1'b0;
      end else begin
        m_den = m_dreq;
      end
    end
    if (fin) m_done = 1'b1;
    else if (wr && address == 2'd2 && writedata[3]) m_done = 1'b0;
    if (wr && address == 2'd0) begin
      m_tgt = writedata[0];
      m_dreq = writedata[1];
`ifdef NIOS_SYSTEM_REVERSE_SEQ_IRQ_EN
      m_ien = writedata[2];
`endif
    end
    if (wr && address == 2'd1) m_dt = writedata[15:0];
    m_irq = m_done & m_ien;
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic busy, pend;
    busy = (m_off != 0) || m_flip || (m_on != 0);
    pend = (m_on != 0) && (m_tgt != m_rev);
    case (a)
      2'd0:    return {29'd0, m_ien, m_dreq, m_tgt};
      2'd1:    return {16'd0, m_dt};
      2'd2:    return {28'd0, m_done, pend, busy, m_rev};
      default: return 32'd0;
    endcase
  endfunction

  // One-cycle bus write, called and returning on a falling edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] rst_exp [4];
    rst_exp = '{32'd0, 32'd1000, 32'd0, 32'd0};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (reverse_out !== 1'b0) begin n_fail++; $display("FAIL reset_rev: got %b expected 0", reverse_out); end
    n_checks++;
    if (drive_en !== 1'b0) begin n_fail++; $display("FAIL reset_drive_en: got %b expected 0", drive_en); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      n_checks++;
      if (readdata !== rst_exp[a]) begin
        n_fail++; $display("FAIL reset_reg%0d: got %0h expected %0h", a, readdata, rst_exp[a]);
      end
    end
  endtask

  task automatic test_basic();
    int busy_cnt = 0, low_cnt = 0, first_busy = -1, first_rev = -1;
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h2);
    bus_write(2'd0, 32'h3);
    for (int i = 0; i < 14; i++) begin
      address = 2'd2;
      #1;
      n_checks++;
      if (drive_en !== m_den || reverse_out !== m_rev || readdata !== exp_read(2'd2)) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: got den=%b rev=%b st=%0h expected den=%b rev=%b st=%0h",
                 i, drive_en, reverse_out, readdata, m_den, m_rev, exp_read(2'd2));
      end
      if (readdata[1]) begin busy_cnt++; if (first_busy < 0) first_busy = i; end
      if (!drive_en) low_cnt++;
      if (reverse_out && first_rev < 0) first_rev = i;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cnt != 9) begin n_fail++; $display("FAIL basic_busy_len: got %0d expected 9", busy_cnt); end
    n_checks++;
    if (low_cnt != 9) begin n_fail++; $display("FAIL basic_drive_low_len: got %0d expected 9", low_cnt); end
    n_checks++;
    if (first_rev - first_busy != 5) begin
      n_fail++; $display("FAIL basic_flip_point: got %0d expected 5", first_rev - first_busy);
    end
    address = 2'd2;
    #1;
    n_checks++;
    if (readdata[3] !== 1'b1 || drive_en !== 1'b1 || reverse_out !== 1'b1) begin
      n_fail++; $display("FAIL basic_final: got done=%b den=%b rev=%b expected 1 1 1", readdata[3], drive_en, reverse_out);
    end
  endtask

  task automatic test_min_deadtime();
    int busy_cnt = 0;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h2);
    repeat (6) @(negedge clk);
    n_checks++;
    if (reverse_out !== 1'b0) begin n_fail++; $display("FAIL min_dt_return: got %b expected 0", reverse_out); end
    bus_write(2'd0, 32'h3);
    for (int i = 0; i < 8; i++) begin
      address = 2'd2;
      #1;
      n_checks++;
      if (drive_en !== m_den || readdata !== exp_read(2'd2)) begin
        n_fail++; $display("FAIL min_dt_cycle%0d: got den=%b st=%0h expected den=%b st=%0h",
                           i, drive_en, readdata, m_den, exp_read(2'd2));
      end
      if (readdata[1]) busy_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_cnt != 3) begin n_fail++; $display("FAIL min_dt_busy_len: got %0d expected 3", busy_cnt); end
    n_checks++;
    if (reverse_out !== 1'b1) begin n_fail++; $display("FAIL min_dt_rev: got %b expected 1", reverse_out); end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0, first_busy = -1, last_busy = -1, hi_cnt = 0;
    logic saw_rev1 = 1'b0;
    logic den_hist [45];
    bus_write(2'd0, 32'h2);
    repeat (5) @(negedge clk);
    bus_write(2'd1, 32'd8);
    bus_write(2'd0, 32'h3);
    for (int i = 0; i < 45; i++) begin
      chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
      #1;
      n_checks++;
      if (drive_en !== m_den || reverse_out !== m_rev || readdata !== exp_read(2'd2)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got den=%b rev=%b st=%0h expected den=%b rev=%b st=%0h",
                 i, drive_en, reverse_out, readdata, m_den, m_rev, exp_read(2'd2));
      end
      den_hist[i] = drive_en;
      if (readdata[1]) begin
        busy_cnt++; last_busy = i;
        if (first_busy < 0) first_busy = i;
      end
      if (reverse_out) saw_rev1 = 1'b1;
      if (i == 3) begin
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    for (int i = 0; i < 45; i++) if (i >= first_busy && i <= last_busy && den_hist[i]) hi_cnt++;
    n_checks++;
    if (busy_cnt != 34 || last_busy - first_busy != 33) begin
      n_fail++; $display("FAIL b2b_busy_len: got %0d span %0d expected 34 span 33", busy_cnt, last_busy - first_busy);
    end
    n_checks++;
    if (hi_cnt != 0) begin n_fail++; $display("FAIL b2b_drive_gap: got %0d high cycles expected 0", hi_cnt); end
    n_checks++;
    if (saw_rev1 !== 1'b1 || reverse_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_direction: got saw1=%b final=%b expected 1 0", saw_rev1, reverse_out);
    end
  endtask

  task automatic test_irq();
    bus_write(2'd2, 32'h8);
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h7);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (irq !== m_irq) begin n_fail++; $display("FAIL irq_cycle%0d: got %b expected %b", i, irq, m_irq); end
      @(negedge clk);
    end
    n_checks++;
    if (irq !== IRQ_BUILD) begin n_fail++; $display("FAIL irq_after_done: got %b expected %b", irq, IRQ_BUILD); end
    address = 2'd0;
    #1;
    n_checks++;
    if (readdata !== {29'd0, IRQ_BUILD, 2'b11}) begin
      n_fail++; $display("FAIL irq_ctrl_read: got %0h expected %0h", readdata, {29'd0, IRQ_BUILD, 2'b11});
    end
    @(negedge clk);
    bus_write(2'd2, 32'h8);
    #1;
    n_checks++;
    if (irq !== 1'b0 || readdata[3] !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got irq=%b done=%b expected 0 0", irq, readdata[3]);
    end
  endtask

  task automatic test_same_dir();
    bus_write(2'd0, 32'h0);
    repeat (8) @(negedge clk);
    bus_write(2'd2, 32'h8);
    n_checks++;
    if (reverse_out !== 1'b0 || drive_en !== 1'b0) begin
      n_fail++; $display("FAIL same_pre: got rev=%b den=%b expected 0 0", reverse_out, drive_en);
    end
    bus_write(2'd0, 32'h2);
    address = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (drive_en !== 1'b1 || readdata[3:1] !== 3'b000 || reverse_out !== 1'b0) begin
        n_fail++; $display("FAIL same_dir_cycle%0d: got den=%b st=%0h expected den=1 st=0", i, drive_en, readdata);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_checks++;
      if (drive_en !== m_den || reverse_out !== m_rev || irq !== m_irq || readdata !== exp_read(address)) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got den=%b rev=%b irq=%b rd[%0d]=%0h expected %b %b %b %0h",
                 i, drive_en, reverse_out, irq, address, readdata, m_den, m_rev, m_irq, exp_read(address));
      end
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = (address == 2'd1) ? {16'($urandom), 16'($urandom_range(0, 5))} : $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic test_reset_mid();
    bus_write(2'd1, 32'd1);
    repeat (20) @(negedge clk);
    bus_write(2'd0, 32'h2);
    repeat (20) @(negedge clk);
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h3);
    repeat (7) @(negedge clk);
    address = 2'd2;
    #1;
    n_checks++;
    if (readdata[1:0] !== 2'b11) begin n_fail++; $display("FAIL mid_on_wait: got st=%0h expected busy,rev set", readdata); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (reverse_out !== 1'b0 || drive_en !== 1'b0 || readdata[1] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out: got rev=%b den=%b busy=%b irq=%b expected 0 0 0 0",
                         reverse_out, drive_en, readdata[1], irq);
    end
    address = 2'd1;
    #1;
    n_checks++;
    if (readdata !== 32'd1000) begin n_fail++; $display("FAIL mid_reset_deadtime: got %0d expected 1000", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (reverse_out !== 1'b0 || drive_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_after: got rev=%b den=%b expected 0 0", reverse_out, drive_en);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_deadtime();
    test_back_to_back();
    test_irq();
    test_same_dir();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
